// File: rtl/hex_scan_ctrl_if.sv
// rtl/hex_scan_ctrl_if.sv - load handshake bundle for the hex scan controller
// Purpose: carries a full display value from the application to the scan controller.
// Signals:
//   load_valid  producer -> controller  load_data holds a new display value
//   load_data   producer -> controller  nibble i = digit i, digit 0 rightmost
//   load_ready  controller -> producer  pending buffer empty
interface hex_scan_ctrl_if #(
   parameter int DIGITS = 4
);
   logic                load_valid;
   logic [4*DIGITS-1:0] load_data;
   logic                load_ready;

   modport master (output load_valid, output load_data, input load_ready);
   modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/hex_scan_ctrl.sv
// rtl/hex_scan_ctrl.sv - multiplexed scan controller for a registered hex-to-7-segment decoder
// Purpose: walks DIGITS common-anode digits, feeding the decoder its 4-bit code (rez) and
//          driving active-low anodes. New values are double-buffered and only take effect
//          on a frame boundary, so a frame never mixes old and new digits.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   load        slave side of the load handshake (valid/data/ready)
//   rez         code to the decoder for the digit being set up or driven
//   dig_n       active-low anode enables, at most one low
//   frame_done  one-cycle pulse on the last DRIVE cycle of the last digit
module hex_scan_ctrl #(
   parameter int DIGITS      = 4,
   parameter int DWELL       = 50000,
   parameter int BLANK       = 16,
   parameter int LZ_SUPPRESS = 1
) (
   input  logic              clk,
   input  logic              rst,
   hex_scan_ctrl_if.slave    load,
   output logic [3:0]        rez,
   output logic [DIGITS-1:0] dig_n,
   output logic              frame_done
);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CMAX  = (DWELL > BLANK) ? DWELL : BLANK;
   localparam int CNT_W = $clog2(CMAX);
   localparam int DW    = 4 * DIGITS;

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DIGITS - 1);
   localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK - 1);
   localparam logic [CNT_W-1:0] DWELL_END = CNT_W'(DWELL - 1);

   typedef enum logic {S_BLANK = 1'b0, S_DRIVE = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DW-1:0]       shadow_q, shadow_d;
   logic [DW-1:0]       pending_q, pending_d;
   logic                pend_full_q, pend_full_d;
   logic [DIGITS-1:0]   dig_n_q, dig_n_d;
   logic [3:0]          rez_q, rez_d;
   logic                frame_done_q, frame_done_d;

   logic                frame_end;
   logic                accept;
   logic [DIGITS-1:0]   lz_blank;
   logic                zero_run;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_BLANK;
         idx_q        <= '0;
         cnt_q        <= '0;
         shadow_q     <= '0;
         pending_q    <= '0;
         pend_full_q  <= 1'b0;
         dig_n_q      <= '1;
         rez_q        <= 4'h0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         shadow_q     <= shadow_d;
         pending_q    <= pending_d;
         pend_full_q  <= pend_full_d;
         dig_n_q      <= dig_n_d;
         rez_q        <= rez_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Next-state logic: scan sequencing and load buffering
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      shadow_d    = shadow_q;
      pending_d   = pending_q;
      pend_full_d = pend_full_q;

      frame_end = (state_q == S_DRIVE) && (idx_q == LAST_IDX) && (cnt_q == DWELL_END);
      accept    = load.load_valid && !pend_full_q;

      if (state_q == S_BLANK) begin
         if (cnt_q == BLANK_END) begin
            state_d = S_DRIVE;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else begin
         if (cnt_q == DWELL_END) begin
            state_d = S_BLANK;
            cnt_d   = '0;
            idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      // Shadow only changes at frame end; accept never coincides with a full buffer,
      // so the two updates to pend_full cannot collide.
      if (frame_end && pend_full_q) begin
         shadow_d    = pending_q;
         pend_full_d = 1'b0;
      end
      if (accept) begin
         pending_d   = load.load_data;
         pend_full_d = 1'b1;
      end
   end

   // Output logic: decoded from next-state values so the registered outputs line up
   // with the state register (a digit's new shadow is already on rez in its first BLANK cycle).
   always_comb begin
      lz_blank = '0;
      zero_run = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_run    = zero_run && (shadow_d[4*i +: 4] == 4'h0);
         lz_blank[i] = (LZ_SUPPRESS != 0) && zero_run;
      end

      dig_n_d = '1;
      rez_d   = 4'h0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_d == IDX_W'(i)) begin
            rez_d = shadow_d[4*i +: 4];
            if (state_d == S_DRIVE && !lz_blank[i]) begin
               dig_n_d[i] = 1'b0;
            end
         end
      end

      frame_done_d = (state_d == S_DRIVE) && (idx_d == LAST_IDX) && (cnt_d == DWELL_END);
   end

   assign load.load_ready = !pend_full_q;
   assign rez             = rez_q;
   assign dig_n           = dig_n_q;
   assign frame_done      = frame_done_q;
endmodule

// File: tb/tb_hex_scan_ctrl.sv
// tb/tb_hex_scan_ctrl.sv - self-checking bench for hex_scan_ctrl
module tb_hex_scan_ctrl;
   localparam int DIGITS = 4;
   localparam int DWELL  = 4;
   localparam int BLANK  = 2;
   localparam int SLOT   = BLANK + DWELL;
   localparam int FRAME  = DIGITS * SLOT;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] rez, rez2;
   logic [3:0] dig_n, dig_n2;
   logic       frame_done, frame_done2;

   hex_scan_ctrl_if #(.DIGITS(DIGITS)) lif ();
   hex_scan_ctrl_if #(.DIGITS(DIGITS)) lif2 ();

   hex_scan_ctrl #(.DIGITS(DIGITS), .DWELL(DWELL), .BLANK(BLANK), .LZ_SUPPRESS(1)) dut (
      .clk(clk), .rst(rst), .load(lif), .rez(rez), .dig_n(dig_n), .frame_done(frame_done));

   hex_scan_ctrl #(.DIGITS(DIGITS), .DWELL(DWELL), .BLANK(BLANK), .LZ_SUPPRESS(0)) dut2 (
      .clk(clk), .rst(rst), .load(lif2), .rez(rez2), .dig_n(dig_n2), .frame_done(frame_done2));

   always #5 clk = ~clk;

   int          checks = 0;
   int          passed = 0;
   int          cyc;
   logic [15:0] lq[$];
   logic [15:0] sb[$];
   bit          acc;
   bit          m_full;
   logic [15:0] m_shadow, m_pend, exp_cur;

   function automatic logic [3:0] model_dig_n(input logic [15:0] v, input int d, input bit lz);
      logic [15:0] upper;
      upper = v >> (4 * d);
      if (lz && d > 0 && upper == 16'h0) return 4'hF;
      return ~(4'h1 << d);
   endfunction

   task automatic drive();
      if (lq.size() > 0) begin
         lif.load_valid = 1'b1;
         lif.load_data  = lq[0];
      end else begin
         lif.load_valid = 1'b0;
      end
      acc = lif.load_valid && lif.load_ready && !rst;
   endtask

   // Advance one cycle; the model follows the edge just taken.
   task automatic tick();
      @(negedge clk);
      #1;
      if (!rst) begin
         if ((cyc % FRAME) == FRAME - 1 && m_full) begin
            m_shadow = m_pend;
            m_full   = 1'b0;
            sb.push_back(m_shadow);
         end
         if (acc) begin
            m_pend = lq.pop_front();
            m_full = 1'b1;
         end
         cyc++;
      end
      drive();
   endtask

   task automatic release_rst();
      rst            = 1'b0;
      lif.load_valid = 1'b0;
      cyc            = 0;
      m_shadow       = '0;
      m_pend         = '0;
      m_full         = 1'b0;
      exp_cur        = '0;
      acc            = 1'b0;
      sb.delete();
      lq.delete();
   endtask

   // A junk load is held during reset; it must be ignored.
   task automatic do_reset();
      rst            = 1'b1;
      lq.delete();
      lif.load_valid = 1'b1;
      lif.load_data  = 16'hBEEF;
      lif2.load_valid = 1'b0;
      lif2.load_data  = 16'h0;
      acc = 1'b0;
      repeat (3) begin
         @(negedge clk);
         #1;
      end
      release_rst();
   endtask

   // Checks whole frames starting at a frame boundary against the model.
   task automatic scan_frame(input string name, input int nframes);
      logic [3:0] ed, er;
      logic       ef, erdy;
      for (int f = 0; f < nframes; f++) begin
         if (sb.size() > 0) exp_cur = sb.pop_front();
         for (int d = 0; d < DIGITS; d++) begin
            for (int k = 0; k < SLOT; k++) begin
               ed   = (k < BLANK) ? 4'hF : model_dig_n(exp_cur, d, 1'b1);
               er   = exp_cur[4*d +: 4];
               ef   = (d == DIGITS - 1) && (k == SLOT - 1);
               erdy = !m_full;
               checks++;
               if (dig_n !== ed) $display("FAIL %s dig_n f%0d d%0d k%0d got %b want %b", name, f, d, k, dig_n, ed);
               else passed++;
               checks++;
               if (rez !== er) $display("FAIL %s rez f%0d d%0d k%0d got %h want %h", name, f, d, k, rez, er);
               else passed++;
               checks++;
               if (frame_done !== ef) $display("FAIL %s frame_done f%0d d%0d k%0d got %b want %b", name, f, d, k, frame_done, ef);
               else passed++;
               checks++;
               if (lif.load_ready !== erdy) $display("FAIL %s load_ready f%0d d%0d k%0d got %b want %b", name, f, d, k, lif.load_ready, erdy);
               else passed++;
               tick();
            end
         end
      end
   endtask

   task automatic test_reset();
      logic [3:0] ed;
      do_reset();
      checks++;
      if (dig_n !== 4'hF) $display("FAIL reset dig_n got %b want 1111", dig_n); else passed++;
      checks++;
      if (rez !== 4'h0) $display("FAIL reset rez got %h want 0", rez); else passed++;
      checks++;
      if (lif.load_ready !== 1'b1) $display("FAIL reset load_ready got %b want 1", lif.load_ready); else passed++;
      checks++;
      if (frame_done !== 1'b0) $display("FAIL reset frame_done got %b want 0", frame_done); else passed++;
      // Raw scan order on the non-suppressing instance.
      for (int c = 1; c <= 11; c++) begin
         tick();
         if (c >= 2 && c <= 5) ed = 4'b1110;
         else if (c >= 8) ed = 4'b1101;
         else ed = 4'b1111;
         checks++;
         if (dig_n2 !== ed) $display("FAIL reset_scan cycle %0d dig_n got %b want %b", c, dig_n2, ed);
         else passed++;
      end
   endtask

   task automatic test_load();
      do_reset();
      lq.push_back(16'h12A5);
      drive();
      scan_frame("load_12a5", 2);
   endtask

   task automatic test_lz();
      do_reset();
      lq.push_back(16'h0030);
      drive();
      scan_frame("lz_0030", 2);
      lq.push_back(16'h0000);
      drive();
      scan_frame("lz_0000", 2);
   endtask

   task automatic test_lz_off();
      logic [3:0] ed;
      do_reset();
      for (int d = 0; d < DIGITS; d++) begin
         for (int k = 0; k < SLOT; k++) begin
            ed = (k < BLANK) ? 4'hF : model_dig_n(16'h0, d, 1'b0);
            checks++;
            if (dig_n2 !== ed) $display("FAIL lz_off dig_n d%0d k%0d got %b want %b", d, k, dig_n2, ed);
            else passed++;
            checks++;
            if (rez2 !== 4'h0) $display("FAIL lz_off rez d%0d k%0d got %h want 0", d, k, rez2);
            else passed++;
            checks++;
            if (frame_done2 !== (d == DIGITS - 1 && k == SLOT - 1))
               $display("FAIL lz_off frame_done d%0d k%0d got %b", d, k, frame_done2);
            else passed++;
            checks++;
            if (lif2.load_ready !== 1'b1) $display("FAIL lz_off load_ready d%0d k%0d got %b want 1", d, k, lif2.load_ready);
            else passed++;
            tick();
         end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      lq.push_back(16'h4321);
      lq.push_back(16'h8765);
      drive();
      scan_frame("b2b", 3);
      checks++;
      if (lq.size() != 0) $display("FAIL b2b queue left %0d want 0", lq.size()); else passed++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      lq.push_back(16'h9876);
      lq.push_back(16'h5555);
      drive();
      scan_frame("mid_pre", 1);
      repeat (15) tick();
      // Cycle 39: digit 2 driving, shadow 9876, 5555 pending.
      checks++;
      if (dig_n !== 4'b1011) $display("FAIL mid dig_n got %b want 1011", dig_n); else passed++;
      checks++;
      if (rez !== 4'h8) $display("FAIL mid rez got %h want 8", rez); else passed++;
      checks++;
      if (lif.load_ready !== 1'b0) $display("FAIL mid load_ready got %b want 0", lif.load_ready); else passed++;
      rst = 1'b1;
      drive();
      tick();
      checks++;
      if (dig_n !== 4'hF) $display("FAIL mid_rst dig_n got %b want 1111", dig_n); else passed++;
      checks++;
      if (rez !== 4'h0) $display("FAIL mid_rst rez got %h want 0", rez); else passed++;
      checks++;
      if (lif.load_ready !== 1'b1) $display("FAIL mid_rst load_ready got %b want 1", lif.load_ready); else passed++;
      checks++;
      if (frame_done !== 1'b0) $display("FAIL mid_rst frame_done got %b want 0", frame_done); else passed++;
      release_rst();
      scan_frame("mid_after", 2);
   endtask

   initial begin
      lif.load_valid  = 1'b0;
      lif.load_data   = '0;
      lif2.load_valid = 1'b0;
      lif2.load_data  = '0;
      test_reset();
      test_load();
      test_lz();
      test_lz_off();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
